// File: rtl/booth_mult_32.sv
// rtl/booth_mult_32.sv - sequential 32-bit signed radix-2 Booth multiplier
// Low 32 product bits plus signed-overflow flag; one CLA add/sub per iteration.

module booth_cla8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);
  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;

  function automatic logic [8:0] f_carry(input logic [7:0] g, input logic [7:0] p, input logic cin);
    logic [8:0] c;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return c;
  endfunction

  assign w_g    = i_a & i_b;
  assign w_p    = i_a ^ i_b;
  assign w_c    = f_carry(w_g, w_p, i_cin);
  assign o_sum  = w_p ^ w_c[7:0];
  assign o_cout = w_c[8];
endmodule

module booth_cla32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  logic [4:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar g = 0; g < 4; g++) begin : g_blk
    booth_cla8 u_cla8 (
      .i_a    (i_a[8*g +: 8]),
      .i_b    (i_b[8*g +: 8]),
      .i_cin  (w_carry[g]),
      .o_sum  (o_sum[8*g +: 8]),
      .o_cout (w_carry[g+1])
    );
  end

  assign o_cout = w_carry[4];
endmodule

module booth_mult_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             result_rdy,
  output logic [WIDTH-1:0] result,
  output logic             exception
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_load;

  logic [32:0] r_m;
  logic [32:0] r_acc;
  logic [31:0] r_q;
  logic        r_qm1;
  logic [4:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_exception;
  logic        r_result_rdy;

  logic        w_addsub;
  logic        w_sub;
  logic [32:0] w_mx;
  logic [31:0] w_sum;
  logic        w_c32;
  logic [32:0] w_acc_n;

  // {Q[0],Qm1}: 10 subtracts M, 01 adds M, 00/11 leave ACC alone
  assign w_addsub = r_q[0] ^ r_qm1;
  assign w_sub    = r_q[0] & ~r_qm1;
  assign w_mx     = w_sub ? ~r_m : r_m;

  booth_cla32 u_cla (
    .i_a    (r_acc[31:0]),
    .i_b    (w_mx[31:0]),
    .i_cin  (w_sub),
    .o_sum  (w_sum),
    .o_cout (w_c32)
  );

  assign w_acc_n = w_addsub ? {r_acc[32] ^ w_mx[32] ^ w_c32, w_sum} : r_acc;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_RUN;
          w_load = 1'b1;
        end
      end
      S_RUN: begin
        if (r_cnt == 5'd31) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_next = S_RUN;
          w_load = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_m          <= '0;
      r_acc        <= '0;
      r_q          <= '0;
      r_qm1        <= 1'b0;
      r_cnt        <= '0;
      r_result     <= '0;
      r_exception  <= 1'b0;
      r_result_rdy <= 1'b0;
    end else begin
      r_result_rdy <= 1'b0;
      if (r_state == S_DONE) begin
        r_result     <= r_q;
        r_exception  <= (r_acc[31:0] != {32{r_q[31]}});
        r_result_rdy <= 1'b1;
      end
      if (w_load) begin
        r_m   <= {op_a[31], op_a};
        r_acc <= '0;
        r_q   <= op_b;
        r_qm1 <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_acc <= {w_acc_n[32], w_acc_n[32:1]};
        r_q   <= {w_acc_n[0], r_q[31:1]};
        r_qm1 <= r_q[0];
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  assign busy       = (r_state == S_RUN);
  assign result_rdy = r_result_rdy;
  assign result     = r_result;
  assign exception  = r_exception;
endmodule

// File: tb/tb_booth_mult_32.sv
// tb/tb_booth_mult_32.sv - directed bench for booth_mult_32
module tb_booth_mult_32;
  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        result_rdy;
  logic [31:0] result;
  logic        exception;

  int n_cmp = 0;
  int n_err = 0;

  booth_mult_32 #(.WIDTH(32)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .result_rdy (result_rdy),
    .result     (result),
    .exception  (exception)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    return sa * sb;
  endfunction

  // Called just after an edge while the DUT is idle; p1/p2 are cycles for ignored mid-run starts.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_r,
                        input logic exp_e, input string tag, input int p1, input int p2);
    int rdy_k;
    int rdy_n;
    int busy_n;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clock); #1;
    start  = 1'b0;
    op_a   = 32'hDEAD_BEEF;
    op_b   = 32'h0BAD_F00D;
    rdy_k  = -1;
    rdy_n  = 0;
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clock); #1;
      end
      if (busy) busy_n++;
      if (result_rdy) begin
        rdy_n++;
        if (rdy_k < 0) rdy_k = k;
      end
      start = (k == p1) || (k == p2);
      if (start) begin
        op_a = 32'd7;
        op_b = 32'd7;
      end
    end
    start = 1'b0;
    check({tag, " rdy_edge"}, 64'(rdy_k), 64'd33);
    check({tag, " rdy_count"}, 64'(rdy_n), 64'd1);
    check({tag, " busy_cycles"}, 64'(busy_n), 64'd32);
    check({tag, " result"}, {32'd0, result}, {32'd0, exp_r});
    check({tag, " exception"}, {63'd0, exception}, {63'd0, exp_e});
  endtask

  initial begin
    int          rdy_n;
    int          ks[$];
    logic [31:0] corners [6];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] p;

    resetn = 1'b0;
    start  = 1'b0;
    op_a   = '0;
    op_b   = '0;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset rdy", {63'd0, result_rdy}, 64'd0);
    check("reset result", {32'd0, result}, 64'd0);
    check("reset exception", {63'd0, exception}, 64'd0);

    run_op(32'd3, 32'd5, 32'h0000_000F, 1'b0, "3x5", -1, -1);
    run_op(32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0, "-7x6", -1, -1);
    run_op(32'd0, 32'h8000_0000, 32'h0, 1'b0, "0xmin", -1, -1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "minxm1", -1, -1);
    run_op(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, "2^16sq", -1, -1);
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h1, 1'b1, "maxsq", -1, -1);
    run_op(32'hFFFF_8000, 32'h0001_0000, 32'h8000_0000, 1'b0, "negfit", -1, -1);
    run_op(32'd2, 32'd3, 32'd6, 1'b0, "2x3_midstart", 5, 20);

    // Reset lands on the edge of iteration 17
    op_a  = 32'h1234_5678;
    op_b  = 32'd9;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (16) begin
      @(posedge clock); #1;
    end
    resetn = 1'b0;
    @(posedge clock); #1;
    check("midrst busy", {63'd0, busy}, 64'd0);
    check("midrst rdy", {63'd0, result_rdy}, 64'd0);
    check("midrst result", {32'd0, result}, 64'd0);
    check("midrst exception", {63'd0, exception}, 64'd0);
    resetn = 1'b1;
    rdy_n  = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (result_rdy) rdy_n++;
    end
    check("midrst no_rdy", 64'(rdy_n), 64'd0);
    run_op(32'd4, 32'd4, 32'h10, 1'b0, "4x4_after_rst", -1, -1);

    // Back-to-back: second start rides the DONE cycle
    op_a  = 32'd10;
    op_b  = 32'd10;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clock); #1;
      if (result_rdy) begin
        ks.push_back(k);
        if (ks.size() == 1) check("b2b first result", {32'd0, result}, 64'h64);
        if (ks.size() == 2) check("b2b second result", {32'd0, result}, 64'h1);
      end
      if (k == 33) check("b2b busy_after_restart", {63'd0, busy}, 64'd1);
      start = (k == 32);
      if (k == 32) begin
        op_a = 32'hFFFF_FFFF;
        op_b = 32'hFFFF_FFFF;
      end
    end
    start = 1'b0;
    check("b2b rdy_count", 64'(ks.size()), 64'd2);
    check("b2b first_edge", 64'((ks.size() > 0) ? ks[0] : -1), 64'd33);
    check("b2b second_edge", 64'((ks.size() > 1) ? ks[1] : -1), 64'd66);

    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h3};
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        p = ref_prod(corners[i], corners[j]);
        run_op(corners[i], corners[j], p[31:0], (p[63:32] != {32{p[31]}}),
               $sformatf("corner %h*%h", corners[i], corners[j]), -1, -1);
      end
    end
    for (int i = 0; i < 48; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : {{16{rb[15]}}, 16'($urandom)};
      p  = ref_prod(ra, rb);
      run_op(ra, rb, p[31:0], (p[63:32] != {32{p[31]}}),
             $sformatf("rand %h*%h", ra, rb), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
